// File: rtl/branch_seq_if.sv
// Control/status bundle between the decoder/flag register and the PC sequencer.
// The master drives the instruction controls and flags; the slave is branch_seq.
interface branch_seq_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
);
  logic             start;
  logic             halt_req;
  logic             br_en;
  logic [2:0]       br_cond;
  logic [OFF_W-1:0] br_off;
  logic             jmp_en;
  logic [PC_W-1:0]  jmp_tgt;
  logic             c_flag;
  logic             v_flag;
  logic             z_flag;
  logic [PC_W-1:0]  pc;
  logic             taken;
  logic             flush;
  logic             busy;
  logic             done;

  modport master (
    output start, halt_req, br_en, br_cond, br_off, jmp_en, jmp_tgt,
           c_flag, v_flag, z_flag,
    input  pc, taken, flush, busy, done
  );

  modport slave (
    input  start, halt_req, br_en, br_cond, br_off, jmp_en, jmp_tgt,
           c_flag, v_flag, z_flag,
    output pc, taken, flush, busy, done
  );
endinterface

// File: rtl/branch_seq.sv
// Program-counter sequencer: evaluates branch conditions on the saved ALU flags,
// selects increment / relative branch / absolute jump and inserts a flush bubble.
module branch_seq #(
  parameter int              PC_W     = 10,
  parameter int              OFF_W    = 8,
  parameter logic [PC_W-1:0] START_PC = {PC_W{1'b0}}
) (
  input logic         clk,
  input logic         reset,
  branch_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             taken_q, taken_d;
  logic             flush_q, flush_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [OFF_W-1:0] off_raw;
  logic [PC_W-1:0]  off_ext;
  logic             cond_ok;

  function automatic logic cond_met(input logic [2:0] cond, input logic c,
                                    input logic v, input logic z);
    logic met;
    case (cond)
      3'b000:  met = 1'b1;
      3'b001:  met = z;
      3'b010:  met = ~z;
      3'b011:  met = c;
      3'b100:  met = ~c;
      3'b101:  met = v;
      3'b110:  met = ~v;
      3'b111:  met = 1'b0;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

  assign off_raw = bus.br_off;
  // Sign extension; PC arithmetic then wraps silently modulo 2^PC_W.
  assign off_ext = PC_W'($signed(off_raw));
  assign cond_ok = cond_met(bus.br_cond, bus.c_flag, bus.v_flag, bus.z_flag);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      taken_q <= 1'b0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    flush_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (bus.halt_req) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (bus.jmp_en) begin
          state_d = S_FLUSH;
          pc_d    = bus.jmp_tgt;
          taken_d = 1'b1;
          flush_d = 1'b1;
          busy_d  = 1'b1;
        end else if (bus.br_en && cond_ok) begin
          state_d = S_FLUSH;
          pc_d    = pc_q + off_ext;
          taken_d = 1'b1;
          flush_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          pc_d    = pc_q + PC_W'(1'b1);
          busy_d  = 1'b1;
        end
      end
      // Bubble: every control input is ignored, the redirected pc is held.
      S_FLUSH: begin
        state_d = S_RUN;
        busy_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START_PC;
      end
    endcase
  end

  assign bus.pc    = pc_q;
  assign bus.taken = taken_q;
  assign bus.flush = flush_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: expected per-cycle outputs are queued when
// stimulus is applied and popped for comparison one clock later.
module tb_branch_seq;

  typedef struct packed {
    logic [9:0] pc;
    logic       taken;
    logic       flush;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk;
  logic reset;
  obs_t exp_q[$];
  obs_t got;
  obs_t want;
  int   tests;
  int   fails;

  branch_seq_if #(.PC_W(10), .OFF_W(8)) bus();

  branch_seq #(.PC_W(10), .OFF_W(8), .START_PC(10'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [9:0] p, input logic t, input logic f,
                              input logic b, input logic d);
    return {p, t, f, b, d};
  endfunction

  function automatic obs_t sample();
    return {bus.pc, bus.taken, bus.flush, bus.busy, bus.done};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%h taken=%b flush=%b busy=%b done=%b",
                     o.pc, o.taken, o.flush, o.busy, o.done);
  endfunction

  function automatic logic tb_cond(input int cond, input logic c, input logic v,
                                   input logic z);
    logic [7:0] tbl;
    tbl = {1'b0, ~v, v, ~c, c, ~z, z, 1'b1};
    return tbl[cond];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
    bus.br_en    = 1'b0;
    bus.br_cond  = 3'b000;
    bus.br_off   = 8'h00;
    bus.jmp_en   = 1'b0;
    bus.jmp_tgt  = 10'h000;
    bus.c_flag   = 1'b0;
    bus.v_flag   = 1'b0;
    bus.z_flag   = 1'b0;
  endtask

  task automatic test_reset();
    clr();
    reset     = 1'b1;
    bus.start = 1'b1;
    exp_q.push_back(mk(10'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    tick();
    got = sample();
    want = exp_q.pop_front();
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL reset: got %s, expected %s", fmt(got), fmt(want));
    end
    reset = 1'b0;
    clr();
    exp_q.push_back(mk(10'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    got = sample();
    want = exp_q.pop_front();
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL idle_hold: got %s, expected %s", fmt(got), fmt(want));
    end
  endtask

  task automatic test_run();
    bus.start = 1'b1;
    exp_q.push_back(mk(10'h000, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    clr();
    for (int i = 1; i <= 5; i++) begin
      got = sample();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL run_inc step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      if (i == 3) bus.start = 1'b1;
      if (i < 5) begin
        exp_q.push_back(mk(10'(i), 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_branch();
    logic [9:0] seq_pc[6];
    logic       seq_t[6];
    logic       seq_f[6];
    seq_pc = '{10'd1, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5};
    seq_t  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    seq_f  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      clr();
      if (i == 0 || i == 5) begin
        bus.br_en   = 1'b1;
        bus.br_cond = 3'b001;
        bus.br_off  = 8'hFD;
        bus.z_flag  = (i == 0);
      end else if (i == 1) begin
        bus.jmp_en   = 1'b1;
        bus.jmp_tgt  = 10'h2AA;
        bus.halt_req = 1'b1;
        bus.start    = 1'b1;
        bus.z_flag   = 1'b1;
      end
      exp_q.push_back(mk(seq_pc[i], seq_t[i], seq_f[i], 1'b1, 1'b0));
      tick();
      got = sample();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL branch_z step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
    clr();
  endtask

  task automatic test_jump_wrap();
    logic [9:0] seq_pc[9];
    logic       seq_t[9];
    seq_pc = '{10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h001, 10'h3FF, 10'h3FF, 10'h000};
    seq_t  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      clr();
      case (i)
        0: begin
          bus.jmp_en  = 1'b1;
          bus.jmp_tgt = 10'h3FF;
          bus.br_en   = 1'b1;
          bus.br_off  = 8'h10;
        end
        2: begin
          bus.br_en   = 1'b1;
          bus.br_cond = 3'b111;
          bus.br_off  = 8'h40;
        end
        3: bus.br_en = 1'b1;
        6: begin
          bus.br_en  = 1'b1;
          bus.br_off = 8'hFE;
        end
        default: bus.br_en = 1'b0;
      endcase
      exp_q.push_back(mk(seq_pc[i], seq_t[i], seq_t[i], 1'b1, 1'b0));
      tick();
      got = sample();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL jump_wrap step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
    clr();
  endtask

  task automatic test_cond_sweep();
    logic [9:0] epc;
    logic       et;
    epc = 10'h100;
    bus.jmp_en  = 1'b1;
    bus.jmp_tgt = epc;
    tick();
    clr();
    tick();
    for (int cond = 0; cond < 8; cond++) begin
      for (int f = 0; f < 8; f++) begin
        bus.br_en   = 1'b1;
        bus.br_cond = 3'(cond);
        bus.br_off  = 8'd2;
        bus.c_flag  = f[2];
        bus.v_flag  = f[1];
        bus.z_flag  = f[0];
        et = tb_cond(cond, f[2], f[1], f[0]);
        epc = et ? epc + 10'd2 : epc + 10'd1;
        exp_q.push_back(mk(epc, et, et, 1'b1, 1'b0));
        tick();
        got = sample();
        want = exp_q.pop_front();
        tests++;
        if (got !== want) begin
          fails++;
          $display("FAIL cond_sweep cond=%0d cvz=%03b: got %s, expected %s",
                   cond, f[2:0], fmt(got), fmt(want));
        end
        if (et) begin
          bus.br_cond = 3'b000;
          bus.z_flag  = ~bus.z_flag;
          bus.c_flag  = ~bus.c_flag;
          exp_q.push_back(mk(epc, 1'b0, 1'b0, 1'b1, 1'b0));
          tick();
          got = sample();
          want = exp_q.pop_front();
          tests++;
          if (got !== want) begin
            fails++;
            $display("FAIL cond_flush cond=%0d cvz=%03b: got %s, expected %s",
                     cond, f[2:0], fmt(got), fmt(want));
          end
        end
      end
    end
    clr();
  endtask

  task automatic test_halt();
    logic [9:0] seq_pc[8];
    logic [3:0] seq_tfbd[8];
    seq_pc   = '{10'd7, 10'd7, 10'd7, 10'd7, 10'd7, 10'd7, 10'd0, 10'd1};
    seq_tfbd = '{4'b1110, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
    for (int i = 0; i < 8; i++) begin
      clr();
      if (i == 0) begin
        bus.jmp_en  = 1'b1;
        bus.jmp_tgt = 10'd7;
      end else if (i >= 2 && i <= 5) begin
        bus.halt_req = 1'b1;
        bus.br_en    = 1'b1;
        bus.br_off   = 8'd5;
        bus.jmp_en   = (i == 3);
        bus.jmp_tgt  = 10'h123;
      end else if (i == 6) begin
        bus.start = 1'b1;
      end
      exp_q.push_back(mk(seq_pc[i], seq_tfbd[i][3], seq_tfbd[i][2], seq_tfbd[i][1], seq_tfbd[i][0]));
      tick();
      got = sample();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL halt step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
    clr();
  endtask

  task automatic test_reset_in_flush();
    logic [9:0] seq_pc[5];
    logic [2:0] seq_tfb[5];
    seq_pc  = '{10'h155, 10'h000, 10'h000, 10'h000, 10'h001};
    seq_tfb = '{3'b111, 3'b000, 3'b000, 3'b001, 3'b001};
    for (int i = 0; i < 5; i++) begin
      clr();
      reset = (i == 1);
      if (i <= 1) begin
        bus.jmp_en  = 1'b1;
        bus.jmp_tgt = 10'h155;
      end
      if (i == 3) bus.start = 1'b1;
      exp_q.push_back(mk(seq_pc[i], seq_tfb[i][2], seq_tfb[i][1], seq_tfb[i][0], 1'b0));
      tick();
      got = sample();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL reset_in_flush step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
    reset = 1'b0;
    clr();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    clr();
    test_reset();
    test_run();
    test_branch();
    test_jump_wrap();
    test_cond_sweep();
    test_halt();
    test_reset_in_flush();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
